// File: rtl/fft_pkg.sv
// Shared types and helpers for the inverse-FFT output path.
//   sample_t    : signed sample at the default component width (DEF_W+1 bits)
//   cplx_t      : complex pair {re, im} of sample_t
//   idx_width() : index width for an N-point frame, max(1, clog2(N))
//   state_t     : frame serializer FSM states
package fft_pkg;

  localparam int unsigned DEF_W = 15;

  typedef logic signed [DEF_W:0] sample_t;

  typedef struct packed {
    sample_t re;
    sample_t im;
  } cplx_t;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fft_frame_serializer.sv
// Frame serializer at the end of the inverse-FFT path. Captures one complete
// N-point complex frame in a single cycle and streams it out one sample per
// cycle, index order 0..N-1, over valid/ready. A new frame may be captured on
// the final handshake of the current one, so consecutive frames have no bubble.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid        x_in holds a complete frame
//   in_ready        frame is captured this cycle if in_valid is high
//   x_in            frame; [k][0] = real, [k][1] = imaginary, W+1 bits each
//   out_valid       out_re/out_im/out_idx/out_last are valid
//   out_ready       consumer accepts the current sample
//   out_re, out_im  components of sample out_idx
//   out_idx         sample index, IDX_W bits
//   out_last        high on the final sample of the frame
//   frame_cnt       fully emitted frames, wraps modulo 2^16
module fft_frame_serializer
  import fft_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 15,
  localparam int unsigned IDX_W = idx_width(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0][1:0][W:0] x_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [W:0]      out_re,
  output logic signed [W:0]      out_im,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic [15:0]            frame_cnt
);

  typedef logic [N-1:0][1:0][W:0] frame_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t          state_q;
  state_t          state_d;
  frame_t          frame_buf;
  logic [IDX_W-1:0] idx;
  logic            at_last;
  logic            streaming;
  logic            handshake;
  logic            capture;

  assign streaming = (state_q == STREAM);
  assign at_last   = (idx == LAST_IDX);
  assign handshake = streaming && out_ready;

  // All outputs read registered state only, so they are stable under
  // backpressure and return to zero the instant rst asserts.
  assign out_valid = streaming;
  assign out_re    = frame_buf[idx][0];
  assign out_im    = frame_buf[idx][1];
  assign out_idx   = idx;
  // Gated by state so the N = 1 case still reads 0 out of reset.
  assign out_last  = streaming && at_last;

  always_comb begin
    in_ready = 1'b0;
    state_d  = state_q;
    if (!rst) begin
      unique case (state_q)
        IDLE:    in_ready = 1'b1;
        STREAM:  in_ready = out_ready && at_last;
        default: in_ready = 1'b0;
      endcase
    end
    capture = in_valid && in_ready;
    unique case (state_q)
      IDLE: begin
        if (capture) state_d = STREAM;
      end
      STREAM: begin
        if (handshake && at_last) state_d = capture ? STREAM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_buf <= '0;
      idx       <= '0;
      frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      // Capture takes priority: on a back-to-back edge the final handshake
      // and the new frame load coincide, and idx must restart at 0.
      if (capture) begin
        frame_buf <= x_in;
        idx       <= '0;
      end else if (handshake) begin
        idx <= at_last ? '0 : idx + IDX_W'(1);
      end
      if (handshake && at_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: doc/fft_frame_serializer.md
Name: fft_frame_serializer

Overview:
- Output stage directly downstream of the 1/N scaling stage at the end of the inverse-FFT path.
- Captures one complete N-point complex frame from the parallel scaled output array in a single cycle.
- Streams the frame out one complex sample per cycle, in index order 0..N-1, over a valid/ready interface to the consumer.
- Back-to-back frames are supported with no bubble between them.

Parameters:
- N, 8, points per frame; any integer >= 1, not restricted to powers of two.
- W, 15, MSB index of each signed component; every component is W+1 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  x_in holds a complete frame.
- in_ready  output  1  block will capture x_in this cycle if in_valid is high.
- x_in  input  [N][2] x (W+1) signed  frame; [k][0] = real part, [k][1] = imaginary part.
- out_valid  output  1  out_re, out_im, out_idx and out_last are valid.
- out_ready  input  1  consumer accepts the current sample.
- out_re  output  W+1 signed  real part of sample out_idx.
- out_im  output  W+1 signed  imaginary part of sample out_idx.
- out_idx  output  IDX_W  sample index; IDX_W = max(1, clog2(N)).
- out_last  output  1  high when out_idx == N-1.
- frame_cnt  output  16  count of fully emitted frames; wraps modulo 2^16.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high, port rst.
- Reset values: state = IDLE, frame buffer = 0, out_valid = 0, out_re = out_im = 0, out_idx = 0, out_last = 0, frame_cnt = 0.
- in_ready is forced to 0 while rst is asserted.
- FSM state IDLE:
  - in_ready = 1.
  - On in_valid: copy all of x_in into the frame buffer, set idx = 0, go to STREAM.
- FSM state STREAM:
  - out_valid = 1; outputs are driven from buffer[idx].
  - A handshake (out_valid && out_ready) advances idx by 1.
  - Handshake while out_last = 1: frame_cnt increments; the next state depends on in_valid (see back-to-back rule).
- Latency: frame captured at edge t -> out_valid = 1 with idx 0 from edge t onward (registered outputs). Minimum N cycles per frame with out_ready held high.
- Back-to-back rule:
  - in_ready = IDLE || (STREAM && out_ready && out_last). This is combinational from state and out_ready.
  - If in_valid is high on the final handshake, the new frame is captured in the same edge, idx = 0, and the FSM stays in STREAM with no bubble.
  - Otherwise the FSM returns to IDLE and out_valid = 0 in the next cycle.
- Backpressure: while out_valid && !out_ready, out_re, out_im, out_idx and out_last are held stable, and the buffer is not written.
- x_in is sampled only on a capture edge; changes to x_in at other times have no effect.
- Index wrap: idx counts 0..N-1 and returns to 0 after N-1; it never reaches 2^IDX_W - 1 unless N = 2^IDX_W. Example: N = 5 gives the sequence 0,1,2,3,4,0.
- N = 1: IDX_W = 1, out_idx is always 0, out_last is always 1, and every handshake completes a frame.
- Data width: components are passed through bit-exact; no arithmetic, no sign change, no truncation.
- Reset mid-frame: the remaining samples are discarded; all outputs return to reset values immediately, asynchronously. The first frame after reset release is accepted from IDLE.
- Driving the outputs from the post-reset zero frame is allowed in IDLE, because out_valid = 0 there.

Decomposition:
- Shared package fft_pkg provides:
  - parameterised signed sample type, W+1 bits;
  - complex pair type;
  - idx_width(N) function returning max(1, clog2(N));
  - state enum {IDLE, STREAM}.
- No sub-module. The frame buffer, index counter and FSM are a single module of roughly 150 lines.

Test Plan:
- N = 8, W = 15; x_in[k] = {k+1, -(k+1)}; one in_valid pulse; out_ready = 1 -> in_ready high in that cycle; 8 consecutive beats (1,-1)..(8,-8); out_idx 0..7; out_last on beat 8 only; frame_cnt = 1; out_valid low afterwards.
- Same frame; out_ready low on cycles 2-4 of streaming -> sample idx 1 = (2,-2) held stable for 3 cycles; no sample skipped or duplicated; total 11 cycles.
- Two frames A[k] = {k, k} and B[k] = {100+k, -100-k}, with in_valid high continuously -> 16 contiguous beats with no gap; B captured on A's last handshake; in_ready low during A beats 0-6; frame_cnt = 2.
- N = 5 -> out_idx sequence 0,1,2,3,4, last on idx 4, next frame starts at idx 0. N = 1 -> out_last is always 1; each beat increments frame_cnt.
- Extremes: x_in components set to -32768 and 32767 -> output exactly -32768 and 32767 (no sign corruption).
- Assert rst asynchronously mid-cycle at idx 3 -> out_valid, out_* and frame_cnt go to 0 immediately; after release the next frame streams from idx 0 and the old frame's data never appears.
